// File: rtl/acc_ctrl_pkg.sv
// Shared types and encodings for the accumulator processor main control FSM:
// state enum, opcode constants, PCSrc / ALUSrcB / ALUOp encodings and an
// opcode legality helper.
package acc_ctrl_pkg;

  localparam int unsigned OPCODE_WIDTH  = 4;
  localparam int unsigned PCSRC_WIDTH   = 2;
  localparam int unsigned ALUSRCB_WIDTH = 2;
  localparam int unsigned ALUOP_WIDTH   = 2;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_READ  = 4'd3,
    S_ALU_WB    = 4'd4,
    S_LOAD_WB   = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_IMM_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 4'hA;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'hF;

  localparam logic [PCSRC_WIDTH-1:0] PCSRC_PC2    = 2'b00;
  localparam logic [PCSRC_WIDTH-1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [PCSRC_WIDTH-1:0] PCSRC_BRANCH = 2'b10;
  localparam logic [PCSRC_WIDTH-1:0] PCSRC_ZERO   = 2'b11;

  localparam logic [ALUSRCB_WIDTH-1:0] SRCB_MEM    = 2'b00;
  localparam logic [ALUSRCB_WIDTH-1:0] SRCB_CONST2 = 2'b01;
  localparam logic [ALUSRCB_WIDTH-1:0] SRCB_CONST0 = 2'b10;
  localparam logic [ALUSRCB_WIDTH-1:0] SRCB_IMM    = 2'b11;

  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = 2'b00;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = 2'b01;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND = 2'b10;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR  = 2'b11;

  // True for every opcode the decoder dispatches; anything else is a NOP + illegal pulse.
  function automatic logic op_is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op <= OP_ADDI) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/acc_ctrl_outdec.sv
// Combinational output decode for the main control FSM.
// Inputs : state_i (current state), opcode_i (IR opcode), mem_ready_i.
// Outputs: PC update controls, IR/memory strobes, accumulator and ALU selects,
//          halted and illegal. Strobes in FETCH are qualified by mem_ready_i so
//          PC and IR are never written during a fetch stall.
module acc_ctrl_outdec
  import acc_ctrl_pkg::*;
(
  input  state_e                   state_i,
  input  logic [OPCODE_WIDTH-1:0]  opcode_i,
  input  logic                     mem_ready_i,
  output logic                     pc_write_o,
  output logic                     branch_o,
  output logic                     bne_or_beq_o,
  output logic [PCSRC_WIDTH-1:0]   pcsrc_o,
  output logic                     ir_write_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic                     iord_o,
  output logic                     acc_write_o,
  output logic                     acc_src_o,
  output logic                     alu_src_a_o,
  output logic [ALUSRCB_WIDTH-1:0] alu_src_b_o,
  output logic [ALUOP_WIDTH-1:0]   alu_op_o,
  output logic                     halted_o,
  output logic                     illegal_o
);

  always_comb begin
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    bne_or_beq_o = 1'b0;
    pcsrc_o      = PCSRC_PC2;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    acc_write_o  = 1'b0;
    acc_src_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_MEM;
    alu_op_o     = ALUOP_ADD;
    halted_o     = 1'b0;
    illegal_o    = 1'b0;
    unique case (state_i)
      S_FETCH: begin
        // ALU computes PC+2 while memory returns the instruction.
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_CONST2;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut.
        alu_src_b_o = SRCB_IMM;
        illegal_o   = !op_is_legal(opcode_i);
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_ALU_WB: begin
        acc_write_o = 1'b1;
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_MEM;
        alu_op_o    = ALUOP_WIDTH'(opcode_i[1:0]);
      end
      S_LOAD_WB: begin
        acc_write_o = 1'b1;
        acc_src_o   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_IMM_WB: begin
        acc_write_o = 1'b1;
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_BRANCH: begin
        // ACC - 0 drives the Zero flag; PC loads ALUOut when the condition holds.
        branch_o     = 1'b1;
        pcsrc_o      = PCSRC_BRANCH;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = SRCB_CONST0;
        alu_op_o     = ALUOP_SUB;
        bne_or_beq_o = (opcode_i == OP_BEQ);
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pcsrc_o    = PCSRC_JUMP;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_control_fsm.sv
// Multicycle main control FSM for the 16-bit accumulator processor.
// Inputs : CLK, reset (async active-low), opcode (IR[15:12]), mem_ready.
// Outputs: PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite, IorD,
//          AccWrite, AccSrc, ALUSrcA, ALUSrcB, ALUOp, halted, illegal.
// Outputs are decoded from the state register (plus mem_ready in FETCH and
// opcode in DECODE/ALU_WB/BRANCH), so reset forces them all low immediately.
module acc_control_fsm
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned PCSRC_W  = 2
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                Branch,
  output logic                bneOrbeq,
  output logic [PCSRC_W-1:0]  PCSrc,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                AccWrite,
  output logic                AccSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                halted,
  output logic                illegal
);

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op;
  logic [PCSRC_WIDTH-1:0]  pcsrc;

  assign op    = OPCODE_WIDTH'(opcode);
  assign PCSrc = PCSRC_W'(pcsrc);

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= S_START;
    else        state_q <= state_d;
  end

  // Next-state logic; memory states hold until mem_ready, HALT exits only via reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: state_d = S_MEM_READ;
          OP_STORE:                               state_d = S_MEM_WRITE;
          OP_ADDI:                                state_d = S_IMM_WB;
          OP_BEQ, OP_BNE:                         state_d = S_BRANCH;
          OP_J:                                   state_d = S_JUMP;
          OP_HALT:                                state_d = S_HALT;
          default:                                state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: if (mem_ready) state_d = (op == OP_LOAD) ? S_LOAD_WB : S_ALU_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_ALU_WB, S_LOAD_WB, S_IMM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

  acc_ctrl_outdec u_outdec (
    .state_i      (state_q),
    .opcode_i     (op),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (PCWrite),
    .branch_o     (Branch),
    .bne_or_beq_o (bneOrbeq),
    .pcsrc_o      (pcsrc),
    .ir_write_o   (IRWrite),
    .mem_read_o   (MemRead),
    .mem_write_o  (MemWrite),
    .iord_o       (IorD),
    .acc_write_o  (AccWrite),
    .acc_src_o    (AccSrc),
    .alu_src_a_o  (ALUSrcA),
    .alu_src_b_o  (ALUSrcB),
    .alu_op_o     (ALUOp),
    .halted_o     (halted),
    .illegal_o    (illegal)
  );

endmodule

// File: tb/tb_acc_control_fsm.sv
// Self-checking bench for acc_control_fsm. A stimulus process walks whole
// instructions through a per-instruction micro-step model and queues the
// expected control word for every cycle; a monitor pops and compares on the
// falling edge.
module tb_acc_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       br;
    logic       beq;
    logic [1:0] pcsrc;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       accw;
    logic       accsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       halted;
    logic       illegal;
  } outs_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       PCWrite, Branch, bneOrbeq, IRWrite, MemRead, MemWrite, IorD;
  logic       AccWrite, AccSrc, ALUSrcA, halted, illegal;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;

  outs_t act, exp_w;
  outs_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cycle_n  = 0;

  acc_control_fsm #(.OPCODE_W(4), .PCSRC_W(2)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .AccWrite(AccWrite), .AccSrc(AccSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .halted(halted), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  assign act = {PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite, IorD,
                AccWrite, AccSrc, ALUSrcA, ALUSrcB, ALUOp, halted, illegal};

  // Monitor: one expected control word per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    cycle_n <= cycle_n + 1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (act !== exp_w) begin
        failures++;
        $display("FAIL ctrl_word cycle=%0d actual=%b required=%b", cycle_n, act, exp_w);
      end
    end
  end

  function automatic logic legal(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd8) || (op == 4'd9) || (op == 4'd10) || (op == 4'd15);
  endfunction

  function automatic outs_t fetch_e(input logic rdy);
    outs_t e = '0;
    e.mrd  = 1'b1;
    e.srcb = 2'b01;
    e.irw  = rdy;
    e.pcw  = rdy;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the control word expected during it.
  task automatic cyc(input logic rst, input logic [3:0] op, input logic rdy, input outs_t e);
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // n cycles held in reset, then one START cycle after release.
  task automatic reset_seq(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom), 1'($urandom), '0);
    cyc(1'b1, 4'($urandom), 1'($urandom), '0);
  endtask

  // One instruction from FETCH to its last cycle; fs/ms are fetch/memory stall counts.
  task automatic do_instr(input logic [3:0] op, input int fs, input int ms);
    outs_t e;
    for (int i = 0; i < fs; i++) cyc(1'b1, 4'($urandom), 1'b0, fetch_e(1'b0));
    cyc(1'b1, 4'($urandom), 1'b1, fetch_e(1'b1));
    e = '0; e.srcb = 2'b11; e.illegal = !legal(op);
    cyc(1'b1, op, 1'($urandom), e);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        e = '0; e.mrd = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < ms; i++) cyc(1'b1, op, 1'b0, e);
        cyc(1'b1, op, 1'b1, e);
        e = '0; e.accw = 1'b1;
        if (op == 4'd4) e.accsrc = 1'b1;
        else begin e.srca = 1'b1; e.srcb = 2'b00; e.aluop = op[1:0]; end
        cyc(1'b1, op, 1'($urandom), e);
      end
      4'd5: begin
        e = '0; e.mwr = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < ms; i++) cyc(1'b1, op, 1'b0, e);
        cyc(1'b1, op, 1'b1, e);
      end
      4'd6: begin
        e = '0; e.accw = 1'b1; e.srca = 1'b1; e.srcb = 2'b11;
        cyc(1'b1, op, 1'($urandom), e);
      end
      4'd8, 4'd9: begin
        e = '0; e.br = 1'b1; e.pcsrc = 2'b10; e.srca = 1'b1; e.srcb = 2'b10;
        e.aluop = 2'b01; e.beq = (op == 4'd8);
        cyc(1'b1, op, 1'($urandom), e);
      end
      4'd10: begin
        e = '0; e.pcw = 1'b1; e.pcsrc = 2'b01;
        cyc(1'b1, op, 1'($urandom), e);
      end
      4'd15: begin
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 22; i++) cyc(1'b1, 4'($urandom), 1'($urandom), e);
        reset_seq(2);
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rop;
    int fs, ms;
    reset = 1'b0; opcode = 4'd0; mem_ready = 1'b0;
    @(posedge CLK);
    #1;
    reset_seq(3);
    do_instr(4'd0, 0, 0);   // ADD
    do_instr(4'd9, 0, 0);   // BNE
    do_instr(4'd8, 0, 0);   // BEQ
    do_instr(4'd5, 0, 3);   // STORE, 3 stall cycles
    do_instr(4'd4, 1, 2);   // LOAD with stalls
    do_instr(4'd7, 0, 0);   // illegal
    do_instr(4'd10, 0, 0);  // J
    do_instr(4'd6, 0, 0);   // ADDI
    do_instr(4'd15, 0, 0);  // HALT then reset
    // Reset while stalled in FETCH.
    cyc(1'b1, 4'd3, 1'b0, fetch_e(1'b0));
    cyc(1'b1, 4'd3, 1'b0, fetch_e(1'b0));
    reset_seq(1);
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom);
      fs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ms  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      do_instr(rop, fs, ms);
    end
    @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
